util_arbitmux_bp: RTL and testbench
===================================

# util_arbitmux_bp

Packet multiplexer with two-dimensional arbitration (priority level × channel) and full valid/ready backpressure. It merges up to CHANNEL_QTY streaming packet sources onto one registered output. It sits between per-channel packet producers (framers, FIFOs) and a single downstream sink that can stall. A grant is locked until the granted channel's end-of-packet beat is accepted, and re-arbitration on that beat is seamless, with no idle cycle between packets.

## Interface
- DATA_WIDTH, 64, data bits per beat
- EMPT_WIDTH, $clog2(DATA_WIDTH/8) (minimum 1), empty-byte count width
- CHANNEL_QTY, 6, input channels, 1..32
- ARBIT_LEVEL, 2, priority levels, minimum 1; level ARBIT_LEVEL-1 is highest
- ARBIT_ALGORITHM, 1, 0 = fixed priority (lowest channel index wins), 1 = round robin per level
- INDX_WIDTH, 10, beat-index counter width
- clk  in  1  clock, posedge; single clock domain
- rst_n  in  1  asynchronous active-low reset
- din_sop / din_eop / din_valid  in  CHANNEL_QTY  per-channel packet framing and valid
- din_data  in  [DATA_WIDTH] × CHANNEL_QTY  per-channel data
- din_empty  in  [EMPT_WIDTH] × CHANNEL_QTY  per-channel empty bytes (meaningful on eop)
- din_ready  out  CHANNEL_QTY  per-channel accept; only the granted bit can be 1
- arbit_request  in  [ARBIT_LEVEL] × CHANNEL_QTY  per-channel, per-level request
- arbit_grant  out  CHANNEL_QTY  one-hot registered grant; 0 when idle
- arbit_channel  out  $clog2(CHANNEL_QTY) (minimum 1)  binary index of granted channel
- arbit_index  out  INDX_WIDTH  index of the next beat to be accepted in the current packet
- dout_sop / dout_eop / dout_valid  out  1  registered output framing
- dout_data  out  DATA_WIDTH  registered output data
- dout_empty  out  EMPT_WIDTH  registered output empty
- dout_ready  in  1  downstream accept

## Operation
- Reset values: all outputs 0. FSM returns to IDLE. Round-robin pointers reset to channel CHANNEL_QTY-1, so channel 0 wins first.
- FSM states:
  - IDLE: no grant. If any request bit is set, register the arbitration result into arbit_grant and go to XFER.
  - XFER: grant is held irrespective of arbit_request.
- Arbitration:
  - The highest level with any request is selected.
  - Within that level, the grant goes to the lowest-index requester (ALGORITHM 0), or to the first requester strictly after that level's pointer, wrapping (ALGORITHM 1).
  - The pointer of the winning level is updated to the winner when the grant is registered. Other levels' pointers are unchanged.
- Beat acceptance: accept = din_valid[g] & din_ready[g].
  - din_ready[g] = grant[g] & (~dout_valid | dout_ready).
  - Beats on non-granted channels are ignored.
- On an accepted beat with din_eop[g] = 1:
  - If any request is present in that cycle, the next grant is registered at the same edge and the FSM stays in XFER (zero bubble).
  - Otherwise the grant clears and the FSM goes to IDLE.
- A channel requesting again right after its own packet does not win while another channel at the same level requests (round robin).
- arbit_index:
  - Increments on each accepted beat, saturating at all-ones.
  - Clears to 0 on accepted eop.
- Output stage:
  - The output register loads on accept.
  - dout_valid clears when dout_ready is high and no new beat is accepted.
  - While dout_valid=1 and dout_ready=0, all dout_* hold stable.
- Single-beat packet (sop & eop on the same beat) is legal.
- An eop without a preceding sop is forwarded unchanged; no checking.

## Timing
- Request in cycle 0 (IDLE) → arbit_grant and din_ready valid in cycle 1.
- First beat accepted at the end of cycle 1 → dout_valid in cycle 2. Input-to-output latency is 1 cycle.
- Sustained throughput is 1 beat/cycle, including across packet boundaries.
- din_ready has a combinational path from dout_ready (default build).
- rst_n assertion mid-packet clears everything immediately. The partial packet is dropped and no eop is emitted.

## Configuration
- UTIL_ARBITMUX_BP_SKID_EN defined:
  - A 2-entry skid buffer is inserted ahead of the output register.
  - din_ready becomes a register (grant & skid not full), with no combinational path from dout_ready.
  - Latency becomes 1 cycle when the skid is empty; throughput is unchanged.
- Undefined: behaviour exactly as described above.

## Structure
- Package util_arbitmux_pkg holds:
  - FSM state enum (IDLE, XFER)
  - BIT_WIDTH/clog2 helper function
  - ARBIT_FIXED / ARBIT_RR algorithm constants
- Sub-module util_arbit_rr, one instance per level:
  - Inputs: request vector, pointer, update strobe
  - Outputs: one-hot grant and any-request flag

## Test plan
- Channels 0 and 2 request level 0; each sends 3-beat packets with dout_ready=1 → grants alternate 0, 2, 0 with no idle cycle; dout_valid is continuous.
- Ch1 requests level 0 and ch4 requests level 1 simultaneously → ch4 is granted first. Ch1 is granted on the beat after ch4's eop is accepted.
- Mid-packet, hold dout_ready=0 for 5 cycles → din_ready[g]=0 and dout_* are stable. Resume → no beat lost or duplicated, and arbit_index continues from its value.
- Send a single-beat packet (sop=eop=1, empty=5) on ch3 → dout shows sop=eop=1 with empty=5. Grant releases after that beat.
- ALGORITHM=0 with ch0 and ch5 requesting continuously → ch0 is granted every time.
- Assert rst_n low on beat 2 of a 4-beat packet → all outputs are 0 asynchronously. After release, the next request is granted 1 cycle later.

Source files
------------

// File: rtl/util_arbitmux_pkg.sv
// Shared types and helpers for the util_arbitmux_bp packet multiplexer.
// Holds the arbiter FSM state encoding, the arbitration algorithm selectors
// and a width helper that never returns less than one bit.
package util_arbitmux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int ARBIT_FIXED = 0;
    localparam int ARBIT_RR    = 1;

    // Bits needed to index n items, with a floor of one bit.
    function automatic int bit_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/util_arbit_rr.sv
// Single-level channel arbiter.
// Fixed priority: lowest requesting index wins.
// Round robin: first requester strictly after the stored pointer, wrapping;
// the pointer moves to the winner when the parent registers this level's grant.
module util_arbit_rr
    import util_arbitmux_pkg::*;
#(
    parameter int  CHANNEL_QTY     = 6,
    parameter int  ARBIT_ALGORITHM = ARBIT_RR,
    localparam int CH_W            = bit_width(CHANNEL_QTY)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNEL_QTY-1:0] request,
    input  logic                   update,
    output logic [CHANNEL_QTY-1:0] grant,
    output logic                   any_req
);

    logic [CH_W-1:0]        ptr_reg;
    logic [CH_W-1:0]        grant_idx;
    logic [CHANNEL_QTY-1:0] above_req;
    logic [CHANNEL_QTY-1:0] pick;

    assign any_req = |request;

    // Pick the candidate set, isolate its lowest set bit, and encode the winner.
    always_comb begin
        above_req = '0;
        for (int i = 0; i < CHANNEL_QTY; i++) begin
            above_req[i] = request[i] & (CH_W'(i) > ptr_reg);
        end
        if ((ARBIT_ALGORITHM == ARBIT_FIXED) || (above_req == '0)) begin
            pick = request;
        end else begin
            pick = above_req;
        end
        grant     = pick & (~pick + CHANNEL_QTY'(1));
        grant_idx = '0;
        for (int i = 0; i < CHANNEL_QTY; i++) begin
            if (grant[i]) begin
                grant_idx = CH_W'(i);
            end
        end
    end

    // Pointer starts on the last channel so channel 0 is the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= CH_W'(CHANNEL_QTY - 1);
        end else if (update && any_req) begin
            ptr_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/util_arbitmux_bp.sv
// util_arbitmux_bp: packet multiplexer with level x channel arbitration and
// valid/ready backpressure. A grant stays locked until the granted channel's
// eop beat is accepted; the next grant is taken on that same edge.
// Optional build macro UTIL_ARBITMUX_BP_SKID_EN adds a 2-entry skid buffer
// ahead of the output register and makes din_ready a register.
module util_arbitmux_bp
    import util_arbitmux_pkg::*;
#(
    parameter int  DATA_WIDTH      = 64,
    parameter int  EMPT_WIDTH      = bit_width(DATA_WIDTH / 8),
    parameter int  CHANNEL_QTY     = 6,
    parameter int  ARBIT_LEVEL     = 2,
    parameter int  ARBIT_ALGORITHM = ARBIT_RR,
    parameter int  INDX_WIDTH      = 10,
    localparam int CH_W            = bit_width(CHANNEL_QTY)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [CHANNEL_QTY-1:0]                   din_sop,
    input  logic [CHANNEL_QTY-1:0]                   din_eop,
    input  logic [CHANNEL_QTY-1:0]                   din_valid,
    input  logic [CHANNEL_QTY-1:0][DATA_WIDTH-1:0]   din_data,
    input  logic [CHANNEL_QTY-1:0][EMPT_WIDTH-1:0]   din_empty,
    output logic [CHANNEL_QTY-1:0]                   din_ready,
    input  logic [ARBIT_LEVEL-1:0][CHANNEL_QTY-1:0]  arbit_request,
    output logic [CHANNEL_QTY-1:0]                   arbit_grant,
    output logic [CH_W-1:0]                          arbit_channel,
    output logic [INDX_WIDTH-1:0]                    arbit_index,
    output logic                                     dout_sop,
    output logic                                     dout_eop,
    output logic                                     dout_valid,
    output logic [DATA_WIDTH-1:0]                    dout_data,
    output logic [EMPT_WIDTH-1:0]                    dout_empty,
    input  logic                                     dout_ready
);

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [EMPT_WIDTH-1:0] empty;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    arb_state_t                             state_reg, state_next;
    logic [CHANNEL_QTY-1:0]                 grant_reg, grant_next;
    logic [CH_W-1:0]                        chan_next;
    logic [ARBIT_LEVEL-1:0][CHANNEL_QTY-1:0] lvl_grant;
    logic [ARBIT_LEVEL-1:0]                 lvl_any, lvl_sel, lvl_update;
    logic [CHANNEL_QTY-1:0]                 arb_grant;
    logic                                   arb_any;
    beat_t                                  sel_beat, out_beat, dout_reg;
    logic                                   accept, accept_eop, load_grant;
    logic                                   out_free, out_load, out_clear;
    logic [INDX_WIDTH-1:0]                  index_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ARBIT_LEVEL; gi++) begin : g_level
            util_arbit_rr #(
                .CHANNEL_QTY    (CHANNEL_QTY),
                .ARBIT_ALGORITHM(ARBIT_ALGORITHM)
            ) u_arbit (
                .clk    (clk),
                .rst_n  (rst_n),
                .request(arbit_request[gi]),
                .update (lvl_update[gi]),
                .grant  (lvl_grant[gi]),
                .any_req(lvl_any[gi])
            );
        end
    endgenerate

    // Highest level with any request supplies the candidate grant.
    always_comb begin
        arb_grant = '0;
        lvl_sel   = '0;
        for (int l = 0; l < ARBIT_LEVEL; l++) begin
            if (lvl_any[l]) begin
                arb_grant  = lvl_grant[l];
                lvl_sel    = '0;
                lvl_sel[l] = 1'b1;
            end
        end
    end

    assign arb_any    = |lvl_any;
    assign lvl_update = lvl_sel & {ARBIT_LEVEL{load_grant}};

    // One-hot mux of the granted channel's beat.
    always_comb begin
        sel_beat = '0;
        for (int c = 0; c < CHANNEL_QTY; c++) begin
            if (grant_reg[c]) begin
                sel_beat.sop   = din_sop[c];
                sel_beat.eop   = din_eop[c];
                sel_beat.empty = din_empty[c];
                sel_beat.data  = din_data[c];
            end
        end
    end

    assign accept     = |(din_valid & din_ready);
    assign accept_eop = accept & sel_beat.eop;
    assign load_grant = arb_any & ((state_reg == IDLE) | accept_eop);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: leave XFER only when the eop lands with nobody waiting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arb_any) state_next = XFER;
            XFER:    if (accept_eop && !arb_any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: next grant (load, release or hold) and its binary index.
    always_comb begin
        grant_next = grant_reg;
        if (load_grant) begin
            grant_next = arb_grant;
        end else if (accept_eop) begin
            grant_next = '0;
        end
        chan_next = '0;
        for (int c = 0; c < CHANNEL_QTY; c++) begin
            if (grant_next[c]) begin
                chan_next = CH_W'(c);
            end
        end
    end

    // Registered grant and channel index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg     <= '0;
            arbit_channel <= '0;
        end else begin
            grant_reg     <= grant_next;
            arbit_channel <= chan_next;
        end
    end

    assign arbit_grant = grant_reg;

    // Beat index within the packet: saturating count, cleared by accepted eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_reg <= '0;
        end else if (accept) begin
            if (accept_eop) begin
                index_reg <= '0;
            end else if (!(&index_reg)) begin
                index_reg <= index_reg + INDX_WIDTH'(1);
            end
        end
    end

    assign arbit_index = index_reg;

`ifdef UTIL_ARBITMUX_BP_SKID_EN
    logic [1:0]             skid_cnt, skid_cnt_next;
    logic                   skid_wr, skid_rd, skid_push, skid_pop;
    logic [CHANNEL_QTY-1:0] ready_reg;
    beat_t                  skid_mem [2];

    // Beats bypass the skid when it is empty and the output can take them.
    assign out_free      = ~dout_valid | dout_ready;
    assign din_ready     = ready_reg;
    assign skid_pop      = out_free & (skid_cnt != 2'd0);
    assign skid_push     = accept & ~(out_free & (skid_cnt == 2'd0));
    assign skid_cnt_next = skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    assign out_load      = out_free & ((skid_cnt != 2'd0) | accept);
    assign out_clear     = out_free;
    assign out_beat      = (skid_cnt != 2'd0) ? skid_mem[skid_rd] : sel_beat;

    // Skid pointers, occupancy and the registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_cnt  <= '0;
            skid_wr   <= 1'b0;
            skid_rd   <= 1'b0;
            ready_reg <= '0;
        end else begin
            skid_cnt  <= skid_cnt_next;
            skid_wr   <= skid_wr ^ skid_push;
            skid_rd   <= skid_rd ^ skid_pop;
            ready_reg <= grant_next & {CHANNEL_QTY{skid_cnt_next != 2'd2}};
        end
    end

    // Skid storage, written on push only.
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_mem[skid_wr] <= sel_beat;
        end
    end
`else
    assign out_free  = ~dout_valid | dout_ready;
    assign din_ready = grant_reg & {CHANNEL_QTY{out_free}};
    assign out_load  = accept;
    assign out_clear = dout_ready;
    assign out_beat  = sel_beat;
`endif

    // Output register: load a new beat, or drop valid once the sink took it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_reg   <= '0;
        end else if (out_load) begin
            dout_valid <= 1'b1;
            dout_reg   <= out_beat;
        end else if (out_clear) begin
            dout_valid <= 1'b0;
        end
    end

    assign dout_sop   = dout_reg.sop;
    assign dout_eop   = dout_reg.eop;
    assign dout_empty = dout_reg.empty;
    assign dout_data  = dout_reg.data;

endmodule

// File: tb/tb_util_arbitmux_bp.sv
// Bench for util_arbitmux_bp: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a packet-level
// model of grants, beat index and the output register.
module tb_util_arbitmux_bp;

    localparam int DW  = 64;
    localparam int EW  = 3;
    localparam int NCH = 6;
    localparam int NL  = 2;
    localparam int IW  = 10;
    localparam int CW  = 3;

    logic                    clk;
    logic                    rst_n;
    logic [NCH-1:0]          din_sop, din_eop, din_valid, din_ready;
    logic [NCH-1:0][DW-1:0]  din_data;
    logic [NCH-1:0][EW-1:0]  din_empty;
    logic [NL-1:0][NCH-1:0]  arbit_request;
    logic [NCH-1:0]          arbit_grant;
    logic [CW-1:0]           arbit_channel;
    logic [IW-1:0]           arbit_index;
    logic                    dout_sop, dout_eop, dout_valid, dout_ready;
    logic [DW-1:0]           dout_data;
    logic [EW-1:0]           dout_empty;

    util_arbitmux_bp #(
        .DATA_WIDTH     (DW),
        .EMPT_WIDTH     (EW),
        .CHANNEL_QTY    (NCH),
        .ARBIT_LEVEL    (NL),
        .ARBIT_ALGORITHM(1),
        .INDX_WIDTH     (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_sop      (din_sop),
        .din_eop      (din_eop),
        .din_valid    (din_valid),
        .din_data     (din_data),
        .din_empty    (din_empty),
        .din_ready    (din_ready),
        .arbit_request(arbit_request),
        .arbit_grant  (arbit_grant),
        .arbit_channel(arbit_channel),
        .arbit_index  (arbit_index),
        .dout_sop     (dout_sop),
        .dout_eop     (dout_eop),
        .dout_valid   (dout_valid),
        .dout_data    (dout_data),
        .dout_empty   (dout_empty),
        .dout_ready   (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: granted channel (-1 idle), per-level RR pointer, index, output beat.
    int            m_g;
    int            m_ptr [NL];
    int            m_idx;
    bit            m_valid, m_sop, m_eop, m_acc;
    int            m_acc_ch;
    logic [DW-1:0] m_data;
    logic [EW-1:0] m_empty;

    // Sources: per-channel packet position, plus request enable and level.
    int            src_len  [NCH];
    int            src_beat [NCH];
    int            src_seq  [NCH];
    logic [EW-1:0] src_emp  [NCH];
    logic [DW-1:0] src_rnd  [NCH];
    bit            req_on   [NCH];
    int            req_lvl  [NCH];
    bit            rnd_mode;
    int            vprob;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_g = -1;
        for (int l = 0; l < NL; l++) m_ptr[l] = NCH - 1;
        m_idx = 0; m_valid = 0; m_sop = 0; m_eop = 0; m_acc = 0; m_acc_ch = -1;
        m_data = '0; m_empty = '0;
    endtask

    task automatic src_reset(input int len);
        for (int c = 0; c < NCH; c++) begin
            src_len[c]  = rnd_mode ? int'($urandom_range(5, 1)) : len;
            src_beat[c] = 0;
            src_seq[c]  = 0;
            src_emp[c]  = rnd_mode ? EW'($urandom) : '0;
            src_rnd[c]  = {$urandom, $urandom};
            req_on[c]   = 1'b0;
            req_lvl[c]  = 0;
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < NCH; c++) begin
            for (int l = 0; l < NL; l++) arbit_request[l][c] = req_on[c] && (req_lvl[c] == l);
            din_valid[c] = int'($urandom_range(99)) < vprob;
            din_sop[c]   = (src_beat[c] == 0);
            din_eop[c]   = (src_beat[c] == src_len[c] - 1);
            din_data[c]  = rnd_mode ? src_rnd[c] : {8'(c), 24'(src_seq[c]), 32'(src_beat[c])};
            din_empty[c] = din_eop[c] ? src_emp[c] : '0;
        end
    endtask

    // One clock: check ready, predict the edge, then check registered outputs.
    task automatic step();
        int             lvl, win;
        bit             out_free, acc_eop;
        logic [NCH-1:0] exp_ready;
        #1;
        out_free  = !m_valid || dout_ready;
        exp_ready = '0;
        if (m_g >= 0 && out_free) exp_ready[m_g] = 1'b1;
        check("din_ready", 64'(din_ready), 64'(exp_ready));
        m_acc    = (m_g >= 0) && out_free && din_valid[m_g];
        m_acc_ch = m_g;
        acc_eop  = m_acc && din_eop[m_g];
        lvl = -1;
        win = -1;
        for (int l = NL - 1; l >= 0; l--) if (lvl < 0 && arbit_request[l] != '0) lvl = l;
        if (lvl >= 0) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr[lvl] + k) % NCH;
                if (win < 0 && arbit_request[lvl][c]) win = c;
            end
        end
        if (m_acc) begin
            m_valid = 1; m_sop = din_sop[m_g]; m_eop = din_eop[m_g];
            m_data = din_data[m_g]; m_empty = din_empty[m_g];
            m_idx = acc_eop ? 0 : ((m_idx == (1 << IW) - 1) ? m_idx : m_idx + 1);
        end else if (dout_ready) begin
            m_valid = 0;
        end
        if (m_g < 0 || acc_eop) begin
            if (win >= 0) begin
                m_g = win;
                m_ptr[lvl] = win;
            end else begin
                m_g = -1;
            end
        end
        @(posedge clk);
        #1;
        check("arbit_grant", 64'(arbit_grant), (m_g < 0) ? 64'd0 : (64'd1 << m_g));
        if (m_g >= 0) check("arbit_channel", 64'(arbit_channel), 64'(m_g));
        check("arbit_index", 64'(arbit_index), 64'(m_idx));
        check("dout_valid", 64'(dout_valid), 64'(m_valid));
        if (m_valid) begin
            check("dout_sop", 64'(dout_sop), 64'(m_sop));
            check("dout_eop", 64'(dout_eop), 64'(m_eop));
            check("dout_data", dout_data, m_data);
            check("dout_empty", 64'(dout_empty), 64'(m_empty));
        end
    endtask

    task automatic advance();
        int c;
        if (m_acc) begin
            c = m_acc_ch;
            if (din_eop[c]) begin
                src_beat[c] = 0;
                src_seq[c]++;
                if (rnd_mode) begin
                    src_len[c] = int'($urandom_range(5, 1));
                    src_emp[c] = EW'($urandom);
                end
            end else begin
                src_beat[c]++;
            end
            src_rnd[c] = {$urandom, $urandom};
        end
    endtask

    task automatic cycle();
        drive_inputs();
        step();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_grant", 64'(arbit_grant), 64'd0);
        check("rst_ready", 64'(din_ready), 64'd0);
        check("rst_channel", 64'(arbit_channel), 64'd0);
        check("rst_index", 64'(arbit_index), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout_sop", 64'(dout_sop), 64'd0);
        check("rst_dout_eop", 64'(dout_eop), 64'd0);
        check("rst_dout_data", dout_data, 64'd0);
        check("rst_dout_empty", 64'(dout_empty), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; dout_ready = 1'b1;
        din_sop = '0; din_eop = '0; din_valid = '0; din_data = '0; din_empty = '0;
        arbit_request = '0;
        vprob = 100; rnd_mode = 0;
        model_reset();
        src_reset(3);
        #2;
        do_reset();

        // Two level-0 requesters, 3-beat packets: 0, 2, 0 with no gap.
        req_on[0] = 1; req_on[2] = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 0) check("t1_grant_ch0", 64'(arbit_grant), 64'h01);
            if (i == 3) check("t1_grant_ch2", 64'(arbit_grant), 64'h04);
            if (i == 6) check("t1_grant_ch0_again", 64'(arbit_grant), 64'h01);
            if (i >= 1) check("t1_continuous", 64'(dout_valid), 64'd1);
        end

        // Level 1 beats level 0; level-0 channel follows the eop directly.
        do_reset(); src_reset(2);
        req_on[1] = 1; req_lvl[1] = 0; req_on[4] = 1; req_lvl[4] = 1;
        cycle();
        check("t2_high_level", 64'(arbit_grant), 64'h10);
        req_on[4] = 0;
        cycle(); cycle();
        check("t2_low_after_eop", 64'(arbit_grant), 64'h02);

        // Sink stall mid-packet for 5 cycles, then resume.
        do_reset(); src_reset(6);
        req_on[3] = 1;
        cycle(); cycle(); cycle();
        req_on[3] = 0;
        dout_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_data", dout_data, 64'h0300_0000_0000_0001);
            check("t3_hold_index", 64'(arbit_index), 64'd2);
        end
        dout_ready = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) check("t3_resume_data", dout_data, 64'h0300_0000_0000_0002);
        end

        // Single-beat packet with empty = 5.
        do_reset(); src_reset(1);
        src_emp[3] = 3'd5; req_on[3] = 1;
        cycle();
        req_on[3] = 0;
        cycle();
        check("t4_release", 64'(arbit_grant), 64'd0);
        check("t4_sop", 64'(dout_sop), 64'd1);
        check("t4_eop", 64'(dout_eop), 64'd1);
        check("t4_empty", 64'(dout_empty), 64'd5);

        // Long packet: index saturates, then clears on eop.
        do_reset(); src_reset(1100);
        req_on[0] = 1;
        for (int i = 0; i <= 1100; i++) begin
            if (i == 1) req_on[0] = 0;
            cycle();
            if (i == 1050) check("t5_index_sat", 64'(arbit_index), 64'd1023);
            if (i == 1100) check("t5_index_clear", 64'(arbit_index), 64'd0);
        end

        // Reset during beat 2 of a 4-beat packet, then a fresh request.
        do_reset(); src_reset(4);
        req_on[2] = 1;
        cycle(); cycle(); cycle();
        drive_inputs();
        do_reset(); src_reset(4);
        req_on[5] = 1;
        cycle();
        check("t6_grant_after_reset", 64'(arbit_grant), 64'h20);

        // Randomized traffic, levels and sink stalls.
        rnd_mode = 1; vprob = 80;
        do_reset(); src_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset(); src_reset(1);
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(9) == 0) begin
                    req_on[c]  = ($urandom_range(2) != 0);
                    req_lvl[c] = int'($urandom_range(1));
                end
            end
            dout_ready = ($urandom_range(3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
